// File: rtl/msdap_pkg.sv
// Shared definitions for the MSDAP output stage: shifter states, default
// geometry and channel indices.
package msdap_pkg;

  localparam int unsigned MSDAP_OUT_WIDTH = 40;
  localparam int unsigned MSDAP_NUM_CH    = 2;

  localparam int unsigned CH_L = 0;
  localparam int unsigned CH_R = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } shift_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/msdap_word_fifo.sv
// Synchronous frame FIFO with occupancy count; single-cycle push and pop,
// pointers wrap modulo DEPTH so any DEPTH >= 1 works.
module msdap_word_fifo
  import msdap_pkg::*;
#(
  parameter int unsigned W     = MSDAP_OUT_WIDTH * MSDAP_NUM_CH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_clr,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [W-1:0]                 i_data,
  output logic [W-1:0]                 o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int unsigned PW = clog2_min1(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/msdap_out_serializer.sv
// Multi-channel bit-serial output stage: buffers parallel frames and shifts
// each channel out in lock-step on SCLK, framed by OutReady.
module msdap_out_serializer
  import msdap_pkg::*;
#(
  parameter int unsigned NUM_CH    = MSDAP_NUM_CH,
  parameter int unsigned WIDTH     = MSDAP_OUT_WIDTH,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned GAP       = 0,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic                         SCLK,
  input  logic                         Reset,
  input  logic                         Flush,
  input  logic                         WordValid,
  output logic                         WordReady,
  input  logic [NUM_CH*WIDTH-1:0]      WordData,
  output logic [NUM_CH-1:0]            SerialOut,
  output logic                         OutReady,
  output logic                         Overflow,
  output logic [$clog2(DEPTH+1)-1:0]   Level
);

  localparam int unsigned FW      = NUM_CH * WIDTH;
  localparam int unsigned BW      = clog2_min1(WIDTH);
  localparam int unsigned GW      = clog2_min1(GAP);
  localparam bit          HAS_GAP = (GAP > 0);

  shift_state_e r_state;
  shift_state_e w_state_nxt;

  logic [FW-1:0]     r_sr;
  logic [FW-1:0]     w_sr_nxt;
  logic [FW-1:0]     w_sr_shift;
  logic [BW-1:0]     r_bitcnt;
  logic [BW-1:0]     w_bitcnt_nxt;
  logic [GW-1:0]     r_gapcnt;
  logic [GW-1:0]     w_gapcnt_nxt;
  logic [NUM_CH-1:0] r_serial;
  logic [NUM_CH-1:0] w_serial_nxt;
  logic              r_outready;
  logic              w_outready_nxt;
  logic              r_overflow;

  logic              w_clr;
  logic              w_push;
  logic              w_load;
  logic              w_last;
  logic              w_gap_done;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [FW-1:0]     w_fifo_dout;

  assign w_clr      = Reset | Flush;
  assign WordReady  = ~w_fifo_full;
  assign w_push     = WordValid & WordReady & ~Flush;
  assign w_last     = (r_bitcnt == BW'(WIDTH - 1));
  assign w_gap_done = (r_gapcnt == '0);

  msdap_word_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (SCLK),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_pop   (w_load),
    .i_data  (WordData),
    .o_data  (w_fifo_dout),
    .o_level (Level),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge SCLK) begin
    if (w_clr) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // The final GAP cycle loads directly, so word period is exactly WIDTH+GAP.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty) begin
          w_state_nxt = S_SHIFT;
          w_load      = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          if (HAS_GAP) begin
            w_state_nxt = S_GAP;
          end else if (!w_fifo_empty) begin
            w_state_nxt = S_SHIFT;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (w_gap_done) begin
          if (!w_fifo_empty) begin
            w_state_nxt = S_SHIFT;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sr_shift = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (LSB_FIRST) w_sr_shift[c*WIDTH +: WIDTH] = r_sr[c*WIDTH +: WIDTH] >> 1;
      else           w_sr_shift[c*WIDTH +: WIDTH] = r_sr[c*WIDTH +: WIDTH] << 1;
    end
  end

  always_comb begin
    w_sr_nxt     = r_sr;
    w_bitcnt_nxt = r_bitcnt;
    w_gapcnt_nxt = r_gapcnt;
    if (w_load) begin
      w_sr_nxt     = w_fifo_dout;
      w_bitcnt_nxt = '0;
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (w_last) begin
            w_sr_nxt     = '0;
            w_bitcnt_nxt = '0;
            if (HAS_GAP) w_gapcnt_nxt = GW'(GAP - 1);
          end else begin
            w_sr_nxt     = w_sr_shift;
            w_bitcnt_nxt = r_bitcnt + 1'b1;
          end
        end
        S_GAP: begin
          if (!w_gap_done) w_gapcnt_nxt = r_gapcnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_outready_nxt = (w_state_nxt == S_SHIFT);
    w_serial_nxt   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (LSB_FIRST) w_serial_nxt[c] = w_outready_nxt & w_sr_nxt[c*WIDTH];
      else           w_serial_nxt[c] = w_outready_nxt & w_sr_nxt[c*WIDTH + WIDTH - 1];
    end
  end

  always_ff @(posedge SCLK) begin
    if (w_clr) begin
      r_sr       <= '0;
      r_bitcnt   <= '0;
      r_gapcnt   <= '0;
      r_serial   <= '0;
      r_outready <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_sr       <= w_sr_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_gapcnt   <= w_gapcnt_nxt;
      r_serial   <= w_serial_nxt;
      r_outready <= w_outready_nxt;
      r_overflow <= r_overflow | (WordValid & ~WordReady);
    end
  end

  assign SerialOut = r_serial;
  assign OutReady  = r_outready;
  assign Overflow  = r_overflow;

endmodule

// File: tb/tb_msdap_out_serializer.sv
// Directed bench for msdap_out_serializer: three configurations sharing one
// clock, inputs driven and outputs sampled on the falling edge.
module tb_msdap_out_serializer;
  import msdap_pkg::*;

  logic SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  int checks = 0;
  int errors = 0;

  // u0: defaults (2ch, 40b, depth 4, no gap, MSB first)
  logic        rst0, fl0, wv0, wr0, or0, ov0;
  logic [79:0] wd0;
  logic [1:0]  so0;
  logic [2:0]  lv0;
  // u1: GAP=100 to stall the shifter
  logic        rst1, fl1, wv1, wr1, or1, ov1;
  logic [79:0] wd1;
  logic [1:0]  so1;
  logic [2:0]  lv1;
  // u2: 4ch, 16b, LSB first
  logic        rst2, fl2, wv2, wr2, or2, ov2;
  logic [63:0] wd2;
  logic [3:0]  so2;
  logic [2:0]  lv2;

  msdap_out_serializer u0 (
    .SCLK(SCLK), .Reset(rst0), .Flush(fl0), .WordValid(wv0), .WordReady(wr0),
    .WordData(wd0), .SerialOut(so0), .OutReady(or0), .Overflow(ov0), .Level(lv0)
  );

  msdap_out_serializer #(.GAP(100)) u1 (
    .SCLK(SCLK), .Reset(rst1), .Flush(fl1), .WordValid(wv1), .WordReady(wr1),
    .WordData(wd1), .SerialOut(so1), .OutReady(or1), .Overflow(ov1), .Level(lv1)
  );

  msdap_out_serializer #(.NUM_CH(4), .WIDTH(16), .LSB_FIRST(1'b1)) u2 (
    .SCLK(SCLK), .Reset(rst2), .Flush(fl2), .WordValid(wv2), .WordReady(wr2),
    .WordData(wd2), .SerialOut(so2), .OutReady(or2), .Overflow(ov2), .Level(lv2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for OutReady, then collects 40 MSB-first bits per channel.
  task automatic cap0(input int budget, output logic [39:0] l, output logic [39:0] r,
                      output logic ok);
    int n = 0;
    l = '0; r = '0; ok = 1'b1;
    while (or0 !== 1'b1 && n < budget) begin @(negedge SCLK); n++; end
    if (or0 !== 1'b1) begin ok = 1'b0; return; end
    for (int k = 0; k < 40; k++) begin
      if (or0 !== 1'b1) ok = 1'b0;
      l = {l[38:0], so0[CH_L]};
      r = {r[38:0], so0[CH_R]};
      @(negedge SCLK);
    end
  endtask

  task automatic cap1(input int budget, output logic [39:0] l, output logic [39:0] r,
                      output int n, output logic ok);
    n = 0; l = '0; r = '0; ok = 1'b1;
    while (or1 !== 1'b1 && n < budget) begin @(negedge SCLK); n++; end
    if (or1 !== 1'b1) begin ok = 1'b0; return; end
    for (int k = 0; k < 40; k++) begin
      if (or1 !== 1'b1) ok = 1'b0;
      l = {l[38:0], so1[CH_L]};
      r = {r[38:0], so1[CH_R]};
      @(negedge SCLK);
    end
  endtask

  // Abort a word mid-flight (Flush or Reset), then prove a fresh frame is clean.
  task automatic abort_case(input bit use_reset, input string nm);
    logic [39:0] l, r;
    logic ok;
    int hi;
    for (int i = 0; i < 3; i++) begin
      wv0 = 1'b1;
      wd0 = {40'h1000000000 + 40'(i), 40'hF00000000F + 40'(i)};
      @(negedge SCLK);
    end
    wv0 = 1'b0;
    repeat (19) @(negedge SCLK);
    chk({nm, "_level_before"}, 64'(lv0), 64'd2);
    chk({nm, "_busy_before"}, 64'(or0), 64'd1);
    if (use_reset) rst0 = 1'b1; else fl0 = 1'b1;
    @(negedge SCLK);
    rst0 = 1'b0; fl0 = 1'b0;
    chk({nm, "_outready"}, 64'(or0), 64'd0);
    chk({nm, "_level"}, 64'(lv0), 64'd0);
    chk({nm, "_serial"}, 64'(so0), 64'd0);
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      if (or0 !== 1'b0) hi++;
      @(negedge SCLK);
    end
    chk({nm, "_quiet"}, 64'(hi), 64'd0);
    wv0 = 1'b1;
    wd0 = {40'h0F0F0F0F0F, 40'hC3C3C3C3C3};
    @(negedge SCLK);
    wv0 = 1'b0;
    cap0(20, l, r, ok);
    chk({nm, "_new_ok"}, 64'(ok), 64'd1);
    chk({nm, "_new_L"}, 64'(l), 64'hC3C3C3C3C3);
    chk({nm, "_new_R"}, 64'(r), 64'h0F0F0F0F0F);
  endtask

  initial begin
    logic [39:0] l, r;
    logic        ok;
    logic [39:0] fl[4], fr[4], cl[4], cr[4];
    logic [15:0] w2[4];
    int first, last, hi, maxlv, b, acc, n;

    rst0 = 1; rst1 = 1; rst2 = 1;
    fl0 = 0; fl1 = 0; fl2 = 0;
    wv0 = 0; wv1 = 0; wv2 = 0;
    wd0 = '0; wd1 = '0; wd2 = '0;
    repeat (2) @(negedge SCLK);
    rst0 = 0; rst1 = 0; rst2 = 0;

    chk("rst_outready", 64'(or0), 64'd0);
    chk("rst_serial", 64'(so0), 64'd0);
    chk("rst_overflow", 64'(ov0), 64'd0);
    chk("rst_level", 64'(lv0), 64'd0);
    chk("rst_wordready", 64'(wr0), 64'd1);
    chk("rst_u2_serial", 64'(so2), 64'd0);

    // Single stereo frame
    wv0 = 1'b1;
    wd0 = {40'h00000000FF, 40'h8000000001};
    @(negedge SCLK);
    wv0 = 1'b0;
    chk("t1_level_after_accept", 64'(lv0), 64'd1);
    chk("t1_outready_e0", 64'(or0), 64'd0);
    @(negedge SCLK);
    chk("t1_outready_e1", 64'(or0), 64'd1);
    chk("t1_level_e1", 64'(lv0), 64'd0);
    cap0(5, l, r, ok);
    chk("t1_cap_ok", 64'(ok), 64'd1);
    chk("t1_L", 64'(l), 64'h8000000001);
    chk("t1_R", 64'(r), 64'h00000000FF);
    chk("t1_outready_drop", 64'(or0), 64'd0);

    // Back-to-back frames, GAP=0
    fl[0] = 40'h0123456789; fr[0] = 40'h1111111111;
    fl[1] = 40'hFEDCBA9876; fr[1] = 40'h8000000000;
    fl[2] = 40'hA5A5A5A5A5; fr[2] = 40'h5A5A5A5A5A;
    fl[3] = 40'h000000FFFF; fr[3] = 40'hFFFF000000;
    for (int i = 0; i < 4; i++) begin cl[i] = '0; cr[i] = '0; end
    first = -1; last = -1; hi = 0; maxlv = 0; b = 0;
    for (int i = 0; i < 170; i++) begin
      if (or0 === 1'b1) begin
        if (first < 0) first = i;
        last = i;
        hi++;
        if (b < 160) begin
          cl[b/40] = {cl[b/40][38:0], so0[CH_L]};
          cr[b/40] = {cr[b/40][38:0], so0[CH_R]};
          b++;
        end
      end
      if (int'(lv0) > maxlv) maxlv = int'(lv0);
      wv0 = (i < 4);
      if (i < 4) wd0 = {fr[i], fl[i]};
      @(negedge SCLK);
    end
    wv0 = 1'b0;
    chk("t2_high_cycles", 64'(hi), 64'd160);
    chk("t2_contiguous", 64'(last - first + 1), 64'd160);
    chk("t2_level_peak", 64'(maxlv), 64'd3);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_L%0d", i), 64'(cl[i]), 64'(fl[i]));
      chk($sformatf("t2_R%0d", i), 64'(cr[i]), 64'(fr[i]));
    end

    // Overflow with the shifter stalled by a long gap
    chk("t3_rst_overflow", 64'(ov1), 64'd0);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      wv1 = 1'b1;
      wd1 = {32'h5B5B5B5B, 8'(i), 32'hA0A0A0A0, 8'(i)};
      if (wr1 === 1'b1) acc++;
      @(negedge SCLK);
    end
    wv1 = 1'b0;
    chk("t3_accepts", 64'(acc), 64'd5);
    chk("t3_level_full", 64'(lv1), 64'd4);
    chk("t3_wordready", 64'(wr1), 64'd0);
    chk("t3_overflow", 64'(ov1), 64'd1);
    n = 0;
    while (or1 === 1'b1 && n < 100) begin @(negedge SCLK); n++; end
    chk("t3_frame0_done", 64'(or1), 64'd0);
    for (int f = 1; f <= 4; f++) begin
      cap1(300, l, r, n, ok);
      chk($sformatf("t3_cap%0d_ok", f), 64'(ok), 64'd1);
      chk($sformatf("t3_L%0d", f), 64'(l), {24'h0, 32'hA0A0A0A0, 8'(f)} & 64'hFF_FFFF_FFFF);
      chk($sformatf("t3_R%0d", f), 64'(r), {24'h0, 32'h5B5B5B5B, 8'(f)} & 64'hFF_FFFF_FFFF);
      if (f > 1) chk($sformatf("t3_gap%0d", f), 64'(n), 64'd100);
    end
    hi = 0;
    for (int i = 0; i < 300; i++) begin
      if (or1 !== 1'b0) hi++;
      @(negedge SCLK);
    end
    chk("t3_dropped_absent", 64'(hi), 64'd0);
    chk("t3_overflow_sticky", 64'(ov1), 64'd1);
    fl1 = 1'b1;
    @(negedge SCLK);
    fl1 = 1'b0;
    chk("t3_flush_overflow", 64'(ov1), 64'd0);
    chk("t3_flush_level", 64'(lv1), 64'd0);
    chk("t3_flush_ready", 64'(wr1), 64'd1);

    // LSB first, 4 channels x 16 bits
    wv2 = 1'b1;
    wd2 = {16'h5555, 16'hAAAA, 16'h8000, 16'h0001};
    @(negedge SCLK);
    wv2 = 1'b0;
    n = 0;
    while (or2 !== 1'b1 && n < 10) begin @(negedge SCLK); n++; end
    chk("t4_started", 64'(or2), 64'd1);
    chk("t4_first_ch0", 64'(so2[0]), 64'd1);
    chk("t4_first_ch1", 64'(so2[1]), 64'd0);
    chk("t4_first_ch2", 64'(so2[2]), 64'd0);
    chk("t4_first_ch3", 64'(so2[3]), 64'd1);
    for (int c = 0; c < 4; c++) w2[c] = '0;
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < 4; c++) w2[c][k] = so2[c];
      @(negedge SCLK);
    end
    chk("t4_ch0", 64'(w2[0]), 64'h0001);
    chk("t4_ch1", 64'(w2[1]), 64'h8000);
    chk("t4_ch2", 64'(w2[2]), 64'hAAAA);
    chk("t4_ch3", 64'(w2[3]), 64'h5555);
    chk("t4_done", 64'(or2), 64'd0);

    // Mid-word abort
    abort_case(1'b0, "t5_flush");
    abort_case(1'b1, "t5_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
